// File: rtl/weight_preload_db.sv
// -----------------------------------------------------------------------------
// weight_preload_db
//
// Double-buffered KSIZE x KSIZE weight preload stage for the conv PE array.
// Weight columns arriving from BRAM shift into a shadow bank, one column per
// accepted beat, while the PE array keeps reading the active bank. Once the
// shadow bank holds a full kernel, a swap handshake copies it into the active
// bank in a single cycle, so the next kernel can load while the current one
// is computing.
//
// Ports
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   in_col      one weight column; row r at [r*WBITS +: WBITS]
//   in_valid    in_col valid this cycle
//   in_ready    shadow bank can accept a beat (low while a full kernel waits)
//   flush       synchronous clear of shadow bank and fill count
//   swap_req    level request to promote shadow -> active
//   swap_ack    one-cycle pulse: swap performed
//   fill_cnt    number of columns currently held in the shadow bank
//   w_valid     active bank holds a complete kernel
//   weight_out  active bank; elem[r][c] at [(r*KSIZE+c)*WBITS +: WBITS]
// -----------------------------------------------------------------------------
module weight_preload_db #(
  parameter int KSIZE = 5,
  parameter int WBITS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KSIZE*WBITS-1:0]         in_col,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic [$clog2(KSIZE+1)-1:0]     fill_cnt,
  output logic                           w_valid,
  output logic [KSIZE*KSIZE*WBITS-1:0]   weight_out
);

  localparam int CW    = $clog2(KSIZE+1);
  localparam int BANKW = KSIZE*KSIZE*WBITS;
  localparam logic [CW-1:0] KFULL = CW'(KSIZE);

  // The load state is fully determined by the column count; the enum only
  // names the two phases so the control terms read naturally.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  fill_state_t      fill_state;
  logic [BANKW-1:0] shadow_q;
  logic [BANKW-1:0] active_q;
  logic [BANKW-1:0] shadow_shift;
  logic             beat;
  logic             swap_fire;

  always_comb begin
    fill_state = (fill_cnt == KFULL) ? FULL : FILL;
  end

  // A full, unswapped kernel must never be overwritten, so in_ready drops as
  // soon as the count reaches KSIZE. Beat and swap are mutually exclusive by
  // construction: one needs FILL, the other needs FULL.
  assign in_ready  = (fill_state == FILL);
  assign beat      = in_valid & in_ready & ~flush;
  assign swap_fire = swap_req & (fill_state == FULL) & ~flush;

  // Each row is an independent shift chain: the new column enters at c=0 and
  // every element moves one column deeper, so the oldest beat ends up at the
  // highest column index.
  always_comb begin
    shadow_shift = '0;
    for (int r = 0; r < KSIZE; r++) begin
      shadow_shift[(r*KSIZE)*WBITS +: WBITS] = in_col[r*WBITS +: WBITS];
      for (int c = 1; c < KSIZE; c++) begin
        shadow_shift[(r*KSIZE+c)*WBITS +: WBITS] =
          shadow_q[(r*KSIZE+c-1)*WBITS +: WBITS];
      end
    end
  end

  // Flush only touches the loading side; the kernel in the active bank keeps
  // feeding the PE array. The shadow bank is deliberately left intact on a
  // swap because the next full load rewrites every column anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      fill_cnt <= '0;
      w_valid  <= 1'b0;
      swap_ack <= 1'b0;
    end else if (flush) begin
      shadow_q <= '0;
      fill_cnt <= '0;
      swap_ack <= 1'b0;
    end else if (swap_fire) begin
      active_q <= shadow_q;
      fill_cnt <= '0;
      w_valid  <= 1'b1;
      swap_ack <= 1'b1;
    end else begin
      swap_ack <= 1'b0;
      if (beat) begin
        shadow_q <= shadow_shift;
        fill_cnt <= fill_cnt + CW'(1);
      end
    end
  end

  assign weight_out = active_q;

endmodule

// File: tb/tb_weight_preload_db.sv
// -----------------------------------------------------------------------------
// tb_weight_preload_db
//
// Self-checking bench for weight_preload_db. Instance A uses KSIZE=5/WBITS=1
// for the directed load-order, backpressure, early-swap, flush and reset
// scenarios; instance B uses KSIZE=3/WBITS=8 for two back-to-back kernels
// with random in_valid gaps. A reference model keeps, per instance, the list
// of columns accepted since the last clear and assembles a kernel from that
// list whenever a swap is due.
// -----------------------------------------------------------------------------
module tb_weight_preload_db;

  logic        clk;
  logic        rst_n;

  logic [4:0]  col_a;
  logic        valid_a, flush_a, swap_a;
  logic        ready_a, ack_a, wv_a;
  logic [2:0]  fill_a;
  logic [24:0] wout_a;

  logic [23:0] col_b;
  logic        valid_b, flush_b, swap_b;
  logic        ready_b, ack_b, wv_b;
  logic [1:0]  fill_b;
  logic [71:0] wout_b;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0]  hist_a[$];
  logic [63:0]  hist_b[$];
  logic [127:0] m_act_a, m_act_b;
  logic         m_wv_a, m_wv_b, m_ack_a, m_ack_b;

  weight_preload_db #(.KSIZE(5), .WBITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_col(col_a), .in_valid(valid_a),
    .in_ready(ready_a), .flush(flush_a), .swap_req(swap_a), .swap_ack(ack_a),
    .fill_cnt(fill_a), .w_valid(wv_a), .weight_out(wout_a)
  );

  weight_preload_db #(.KSIZE(3), .WBITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_col(col_b), .in_valid(valid_b),
    .in_ready(ready_b), .flush(flush_b), .swap_req(swap_b), .swap_ack(ack_b),
    .fill_cnt(fill_b), .w_valid(wv_b), .weight_out(wout_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Kernel assembly: the most recent column sits in column 0, the one before
  // it in column 1, and so on; row r of a column is field r of that beat.
  function automatic logic [127:0] model_kernel(input int k, input int w, input bit sel);
    logic [127:0] res;
    logic [63:0]  col;
    res = '0;
    for (int kk = 0; kk < k; kk++) begin
      col = sel ? hist_b[hist_b.size()-1-kk] : hist_a[hist_a.size()-1-kk];
      for (int row = 0; row < k; row++)
        for (int b = 0; b < w; b++)
          res[(row*k+kk)*w+b] = col[row*w+b];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist_a.delete(); hist_b.delete();
    m_act_a = '0; m_act_b = '0;
    m_wv_a = 1'b0; m_wv_b = 1'b0;
    m_ack_a = 1'b0; m_ack_b = 1'b0;
  endtask

  task automatic checkOutput();
    check("a_fill",   128'(fill_a),  128'(hist_a.size()));
    check("a_ready",  128'(ready_a), 128'(hist_a.size() != 5));
    check("a_ack",    128'(ack_a),   128'(m_ack_a));
    check("a_wvalid", 128'(wv_a),    128'(m_wv_a));
    check("a_weight", 128'(wout_a),  m_act_a);
    check("b_fill",   128'(fill_b),  128'(hist_b.size()));
    check("b_ready",  128'(ready_b), 128'(hist_b.size() != 3));
    check("b_ack",    128'(ack_b),   128'(m_ack_b));
    check("b_wvalid", 128'(wv_b),    128'(m_wv_b));
    check("b_weight", 128'(wout_b),  m_act_b);
  endtask

  // One clock: capture the inputs presented before the edge, let the edge
  // happen, advance the model with those inputs, then compare.
  task automatic applyStimulus();
    logic       sa_valid, sa_flush, sa_swap, sb_valid, sb_flush, sb_swap;
    logic [4:0] sa_col;
    logic [23:0] sb_col;
    sa_valid = valid_a; sa_flush = flush_a; sa_swap = swap_a; sa_col = col_a;
    sb_valid = valid_b; sb_flush = flush_b; sb_swap = swap_b; sb_col = col_b;
    @(posedge clk);
    #1;
    if (sa_flush) begin
      hist_a.delete(); m_ack_a = 1'b0;
    end else if (sa_swap && hist_a.size() == 5) begin
      m_act_a = model_kernel(5, 1, 1'b0);
      hist_a.delete(); m_wv_a = 1'b1; m_ack_a = 1'b1;
    end else begin
      m_ack_a = 1'b0;
      if (sa_valid && hist_a.size() < 5) hist_a.push_back(64'(sa_col));
    end
    if (sb_flush) begin
      hist_b.delete(); m_ack_b = 1'b0;
    end else if (sb_swap && hist_b.size() == 3) begin
      m_act_b = model_kernel(3, 8, 1'b1);
      hist_b.delete(); m_wv_b = 1'b1; m_ack_b = 1'b1;
    end else begin
      m_ack_b = 1'b0;
      if (sb_valid && hist_b.size() < 3) hist_b.push_back(64'(sb_col));
    end
    checkOutput();
  endtask

  task automatic beat_a(input logic [4:0] c);
    valid_a = 1'b1;
    col_a   = c;
    applyStimulus();
    valid_a = 1'b0;
  endtask

  initial begin
    int swaps;
    int cyc;

    rst_n = 1'b0;
    col_a = '0; valid_a = 1'b0; flush_a = 1'b0; swap_a = 1'b0;
    col_b = '0; valid_b = 1'b0; flush_b = 1'b0; swap_b = 1'b0;
    model_reset();
    #1;
    checkOutput();
    #11 rst_n = 1'b1;

    // Load order: one-hot columns land on the anti-diagonal
    beat_a(5'h01); beat_a(5'h02); beat_a(5'h04); beat_a(5'h08); beat_a(5'h10);
    swap_a = 1'b1;
    applyStimulus();
    check("t2_ack",    128'(ack_a),  128'(1));
    check("t2_weight", 128'(wout_a), 128'(25'h0111110));
    check("t2_wvalid", 128'(wv_a),   128'(1));
    swap_a = 1'b0;
    applyStimulus();
    check("t2_ack_pulse", 128'(ack_a), 128'(0));

    // Backpressure: a sixth beat waits while the shadow bank is full
    for (int i = 0; i < 5; i++) beat_a(5'($urandom));
    valid_a = 1'b1; col_a = 5'h1F;
    applyStimulus();
    applyStimulus();
    check("t3_ready_low", 128'(ready_a), 128'(0));
    check("t3_fill_hold", 128'(fill_a),  128'(5));
    swap_a = 1'b1;
    applyStimulus();
    check("t3_ack", 128'(ack_a), 128'(1));
    swap_a = 1'b0;
    applyStimulus();
    check("t3_fill_after", 128'(fill_a), 128'(1));
    valid_a = 1'b0;

    // Early swap request is ignored until the kernel is complete
    beat_a(5'($urandom)); beat_a(5'($urandom));
    swap_a = 1'b1;
    applyStimulus();
    check("t4_no_ack", 128'(ack_a), 128'(0));
    beat_a(5'($urandom)); beat_a(5'($urandom));
    check("t4_no_ack_on_fill", 128'(ack_a), 128'(0));
    applyStimulus();
    check("t4_ack", 128'(ack_a), 128'(1));
    swap_a = 1'b0;
    applyStimulus();

    // Flush drops the partial load and the concurrent beat
    for (int i = 0; i < 3; i++) beat_a(5'($urandom));
    flush_a = 1'b1; valid_a = 1'b1; col_a = 5'($urandom);
    applyStimulus();
    check("t5_fill_zero", 128'(fill_a), 128'(0));
    check("t5_wvalid",    128'(wv_a),   128'(1));
    flush_a = 1'b0; valid_a = 1'b0;
    for (int i = 0; i < 4; i++) beat_a(5'($urandom));
    swap_a = 1'b1;
    applyStimulus();
    check("t5_no_ack_at4", 128'(ack_a), 128'(0));
    beat_a(5'($urandom));
    applyStimulus();
    check("t5_ack", 128'(ack_a), 128'(1));
    swap_a = 1'b0;
    applyStimulus();

    // Two back-to-back 3x3 8-bit kernels with random valid gaps
    swaps = 0;
    cyc   = 0;
    while (swaps < 2 && cyc < 300) begin
      valid_b = ($urandom_range(0, 2) != 0);
      col_b   = 24'($urandom);
      swap_b  = (hist_b.size() == 3);
      applyStimulus();
      if (ack_b) swaps++;
      cyc++;
    end
    valid_b = 1'b0; swap_b = 1'b0;
    check("t6_swaps_seen", 128'(swaps), 128'(2));
    applyStimulus();

    // Asynchronous reset mid-run with both active banks loaded
    for (int i = 0; i < 2; i++) beat_a(5'($urandom));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t1_weight", 128'(wout_a), 128'(0));
    check("t1_wvalid", 128'(wv_a),   128'(0));
    check("t1_fill",   128'(fill_a), 128'(0));
    check("t1_ready",  128'(ready_a), 128'(1));
    check("t1_ack",    128'(ack_a),  128'(0));
    checkOutput();
    #2 rst_n = 1'b1;
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
